// File: rtl/fall_tick_pkg.sv
// fall_tick_pkg: shared state encoding, widths and helpers
// for the gravity tick controller.
package fall_tick_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int LEVEL_W   = 4;
    localparam int LINE_N_W  = 3;
    localparam int LTOT_W    = 16;
    localparam int TOT_SUM_W = LTOT_W + 1;
    localparam int ACC_W     = 8;

    localparam logic [LINE_N_W-1:0] LINE_MAX = LINE_N_W'(4);

    // A single clear never counts for more than a tetris.
    function automatic logic [LINE_N_W-1:0] clamp_lines(
        input logic [LINE_N_W-1:0] n
    );
        return (n > LINE_MAX) ? LINE_MAX : n;
    endfunction

endpackage

// File: rtl/fall_tick_edge_gen.sv
// tick_edge_gen: free-running drop counter with a selectable
// bit and a rising-edge detector that turns it into tick pulses.
module tick_edge_gen
    import fall_tick_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int SEL_W    = $clog2(CNT_W),
    parameter int SEL_INIT = 26
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic [SEL_W-1:0] sel,
    output logic             rise
);

    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] sel_q;
    logic             prev;
    logic             bit_now;
    logic             sel_chg;

    assign bit_now = cnt[sel];

    // A freshly switched select compares against a bit sampled
    // from the old position, so that one cycle is not trusted.
    assign sel_chg = (sel != sel_q);

    assign rise = bit_now & ~prev & run & ~sel_chg;

    // Drop counter: cleared by a new game, advances only while running.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Previous sample of the selected bit; always re-primed from
    // the current select so a switch settles within one cycle.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || clr) begin
            prev <= 1'b0;
        end else begin
            prev <= bit_now;
        end
    end

    // Remember last cycle's select to spot a speed change.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sel_q <= SEL_W'(SEL_INIT);
        end else begin
            sel_q <= sel;
        end
    end

endmodule

// File: rtl/fall_tick_ctrl.sv
// fall_tick_ctrl: game-state FSM, speed schedule, line/level
// bookkeeping and the pending-tick handshake on sys_clk.
module fall_tick_ctrl
    import fall_tick_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int SEL_W        = $clog2(CNT_W),
    parameter int SEL_SLOWEST  = 26,
    parameter int SEL_FASTEST  = 20,
    parameter int SEL_DROP     = 16,
    parameter int LINES_PER_LV = 10,
    parameter int MAX_LEVEL    = 15
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                start,
    input  logic                pause,
    input  logic                soft_drop,
    input  logic                game_over,
    input  logic                line_clr,
    input  logic [LINE_N_W-1:0] line_n,
    input  logic                tick_ack,
    output logic                tick_pend,
    output logic                tick_ovr,
    output logic [LEVEL_W-1:0]  level,
    output logic [SEL_W-1:0]    speed_sel,
    output logic [LTOT_W-1:0]   lines_tot,
    output logic                running
);

    localparam int LV_SPAN = SEL_SLOWEST - SEL_FASTEST;

    localparam logic [SEL_W-1:0] SLOW_SEL = SEL_W'(SEL_SLOWEST);
    localparam logic [SEL_W-1:0] FAST_SEL = SEL_W'(SEL_FASTEST);
    localparam logic [SEL_W-1:0] DROP_SEL = SEL_W'(SEL_DROP);

    localparam logic [LEVEL_W-1:0] LV_MAX = LEVEL_W'(MAX_LEVEL);
    localparam logic [ACC_W-1:0]   LPL    = ACC_W'(LINES_PER_LV);

    state_t                state;
    logic [ACC_W-1:0]      acc;
    logic                  start_go;
    logic                  in_run;
    logic                  line_go;
    logic                  rise;
    logic                  lv_up;
    logic [LINE_N_W-1:0]   n_clamped;
    logic [ACC_W-1:0]      acc_sum;
    logic [TOT_SUM_W-1:0]  tot_sum;
    logic [SEL_W-1:0]      base_sel;

    assign in_run   = (state == RUN);
    assign running  = in_run;
    assign start_go = start & ((state == IDLE) | (state == OVER));
    assign line_go  = line_clr & in_run;

    assign n_clamped = clamp_lines(line_n);
    assign acc_sum   = acc + ACC_W'(n_clamped);
    assign lv_up     = (acc_sum >= LPL);
    assign tot_sum   = {1'b0, lines_tot} + TOT_SUM_W'(n_clamped);

    // Level ramp: one counter bit faster per level, floored.
    always_comb begin
        base_sel = FAST_SEL;
        if (int'(level) < LV_SPAN) begin
            base_sel = SLOW_SEL - SEL_W'(level);
        end
    end

    tick_edge_gen #(
        .CNT_W    (CNT_W),
        .SEL_W    (SEL_W),
        .SEL_INIT (SEL_SLOWEST)
    ) u_edge (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (start_go),
        .run       (in_run),
        .sel       (speed_sel),
        .rise      (rise)
    );

    // Game state: game_over beats start beats pause.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (game_over) begin
                        state <= OVER;
                    end else if (pause) begin
                        state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (game_over) begin
                        state <= OVER;
                    end else if (!pause) begin
                        state <= RUN;
                    end
                end
                OVER: begin
                    if (start) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line accumulator, level and lifetime line total.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || start_go) begin
            acc       <= '0;
            level     <= '0;
            lines_tot <= '0;
        end else if (line_go) begin
            if (lv_up) begin
                acc <= acc_sum - LPL;
                if (level != LV_MAX) begin
                    level <= level + LEVEL_W'(1);
                end
            end else begin
                acc <= acc_sum;
            end
            if (tot_sum[LTOT_W]) begin
                lines_tot <= '1;
            end else begin
                lines_tot <= tot_sum[LTOT_W-1:0];
            end
        end
    end

    // Effective counter bit; a new game drops straight to the
    // slowest speed instead of lagging on the old level.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            speed_sel <= SLOW_SEL;
        end else if (start_go) begin
            speed_sel <= soft_drop ? DROP_SEL : SLOW_SEL;
        end else begin
            speed_sel <= soft_drop ? DROP_SEL : base_sel;
        end
    end

    // Pending tick with ack; a tick landing on an unacked one
    // latches the sticky overrun flag.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || start_go) begin
            tick_pend <= 1'b0;
            tick_ovr  <= 1'b0;
        end else if (rise) begin
            tick_pend <= 1'b1;
            if (tick_pend && !tick_ack) begin
                tick_ovr <= 1'b1;
            end
        end else if (tick_ack) begin
            tick_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fall_tick_ctrl.sv
// tb_fall_tick_ctrl: directed vectors and hand-timed sequences
// for the gravity tick controller at reduced widths.
module tb_fall_tick_ctrl;

    localparam int CNT_W        = 8;
    localparam int SEL_W        = 3;
    localparam int SEL_SLOWEST  = 5;
    localparam int SEL_FASTEST  = 2;
    localparam int SEL_DROP     = 1;
    localparam int LINES_PER_LV = 4;
    localparam int MAX_LEVEL    = 3;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic             start;
    logic             pause;
    logic             soft_drop;
    logic             game_over;
    logic             line_clr;
    logic [2:0]       line_n;
    logic             tick_ack;
    logic             tick_pend;
    logic             tick_ovr;
    logic [3:0]       level;
    logic [SEL_W-1:0] speed_sel;
    logic [15:0]      lines_tot;
    logic             running;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       clr;
        logic [2:0] n;
        logic       sd;
        int         lv;
        int         sel;
        int         tot;
    } line_vec_t;

    line_vec_t vt[10];

    always #5 sys_clk = ~sys_clk;

    fall_tick_ctrl #(
        .CNT_W        (CNT_W),
        .SEL_W        (SEL_W),
        .SEL_SLOWEST  (SEL_SLOWEST),
        .SEL_FASTEST  (SEL_FASTEST),
        .SEL_DROP     (SEL_DROP),
        .LINES_PER_LV (LINES_PER_LV),
        .MAX_LEVEL    (MAX_LEVEL)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .pause     (pause),
        .soft_drop (soft_drop),
        .game_over (game_over),
        .line_clr  (line_clr),
        .line_n    (line_n),
        .tick_ack  (tick_ack),
        .tick_pend (tick_pend),
        .tick_ovr  (tick_ovr),
        .level     (level),
        .speed_sel (speed_sel),
        .lines_tot (lines_tot),
        .running   (running)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pend"}, tick_pend, 0);
        chk({tag, "_ovr"}, tick_ovr, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_sel"}, speed_sel, SEL_SLOWEST);
        chk({tag, "_tot"}, lines_tot, 0);
        chk({tag, "_run"}, running, 0);
    endtask

    function automatic bit drop_tick(input int n);
        return n == 33 || n == 71 || n == 75 || n == 79 ||
               n == 83 || n == 97;
    endfunction

    initial begin
        int seen;

        vt[0] = '{1'b1, 3'd3, 1'b0, 0, 5, 3};
        vt[1] = '{1'b1, 3'd2, 1'b0, 1, 4, 5};
        vt[2] = '{1'b1, 3'd0, 1'b0, 1, 4, 5};
        vt[3] = '{1'b0, 3'd4, 1'b0, 1, 4, 5};
        vt[4] = '{1'b1, 3'd4, 1'b0, 2, 3, 9};
        vt[5] = '{1'b1, 3'd7, 1'b0, 3, 2, 13};
        vt[6] = '{1'b1, 3'd4, 1'b0, 3, 2, 17};
        vt[7] = '{1'b1, 3'd4, 1'b0, 3, 2, 21};
        vt[8] = '{1'b0, 3'd0, 1'b1, 3, 1, 21};
        vt[9] = '{1'b0, 3'd0, 1'b0, 3, 2, 21};

        sys_rst_n = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        soft_drop = 1'b0;
        game_over = 1'b0;
        line_clr  = 1'b0;
        line_n    = 3'd0;
        tick_ack  = 1'b0;

        step();
        step();
        chk_reset_vals("reset");
        sys_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("idle_no_run", running, 0);

        // Game 1: acked ticks at E33 then every 64 cycles.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("g1_running", running, 1);
        for (int n = 1; n <= 170; n++) begin
            tick_ack = tick_pend;
            step();
            chk($sformatf("g1_pend_n%0d", n), tick_pend,
                (n % 64 == 33) ? 1 : 0);
        end
        chk("g1_no_ovr", tick_ovr, 0);

        tick_ack  = 1'b0;
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        chk("g1_over", running, 0);

        // Game 2: never acked, overrun on the second rise.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 97; n++) begin
            step();
            chk($sformatf("g2_pend_n%0d", n), tick_pend, (n >= 33) ? 1 : 0);
            chk($sformatf("g2_ovr_n%0d", n), tick_ovr, (n >= 97) ? 1 : 0);
        end
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        chk("g2_over_run", running, 0);
        chk("g2_over_pend_held", tick_pend, 1);
        chk("g2_over_ovr_held", tick_ovr, 1);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("g2_pause_in_over", running, 0);
        pause    = 1'b0;
        tick_ack = 1'b1;
        step();
        tick_ack = 1'b0;
        chk("g2_ack_in_over", tick_pend, 0);
        chk("g2_ovr_sticky", tick_ovr, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("g3_start_ovr", tick_ovr, 0);
        chk("g3_start_pend", tick_pend, 0);
        chk("g3_start_run", running, 1);

        // Game 3: pause 100 cycles after cnt=41.
        for (int n = 1; n <= 40; n++) begin
            tick_ack = tick_pend;
            step();
            chk($sformatf("g3_pend_n%0d", n), tick_pend, (n == 33) ? 1 : 0);
        end
        tick_ack = 1'b0;
        pause    = 1'b1;
        seen     = 0;
        for (int n = 41; n <= 140; n++) begin
            step();
            seen += int'(tick_pend) + int'(running);
        end
        chk("g3_paused_quiet", seen, 0);
        pause = 1'b0;
        for (int n = 141; n <= 197; n++) begin
            tick_ack = tick_pend;
            step();
            chk($sformatf("g3_resume_pend_n%0d", n), tick_pend,
                (n == 197) ? 1 : 0);
        end
        chk("g3_resume_run", running, 1);

        // Line / level / speed table.
        tick_ack = 1'b1;
        foreach (vt[i]) begin
            line_clr  = vt[i].clr;
            line_n    = vt[i].n;
            soft_drop = vt[i].sd;
            step();
            line_clr = 1'b0;
            step();
            chk($sformatf("lines%0d_level", i), level, vt[i].lv);
            chk($sformatf("lines%0d_sel", i), speed_sel, vt[i].sel);
            chk($sformatf("lines%0d_tot", i), lines_tot, vt[i].tot);
        end

        pause = 1'b1;
        step();
        line_clr = 1'b1;
        line_n   = 3'd4;
        step();
        line_clr = 1'b0;
        step();
        chk("pause_lines_ignored", lines_tot, 21);
        chk("pause_not_running", running, 0);
        pause = 1'b0;
        step();
        chk("pause_release", running, 1);

        game_over = 1'b1;
        step();
        game_over = 1'b0;

        // Game 4: soft drop from E66 to E84.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("g4_start_level", level, 0);
        chk("g4_start_tot", lines_tot, 0);
        chk("g4_start_sel", speed_sel, SEL_SLOWEST);
        for (int n = 1; n <= 97; n++) begin
            soft_drop = (n >= 66 && n <= 84);
            step();
            chk($sformatf("g4_pend_n%0d", n), tick_pend,
                drop_tick(n) ? 1 : 0);
            if (n == 66) chk("g4_drop_sel", speed_sel, SEL_DROP);
            if (n == 85) chk("g4_release_sel", speed_sel, SEL_SLOWEST);
        end

        // Reset in the middle of a game.
        tick_ack = 1'b0;
        line_clr = 1'b1;
        line_n   = 3'd3;
        step();
        line_clr = 1'b0;
        chk("pre_rst_pend", tick_pend, 1);
        chk("pre_rst_tot", lines_tot, 3);
        sys_rst_n = 1'b0;
        step();
        chk_reset_vals("midrst");
        sys_rst_n = 1'b1;
        seen      = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            seen += int'(tick_pend) + int'(running);
        end
        chk("post_rst_idle", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
